// File: rtl/approx_err_pkg.sv
// ----------------------------------------------------------------------------
// approx_err_pkg
// Shared definitions for the approximate-adder error accumulator:
//   - default operand width and window size
//   - FSM state encoding
//   - width-derivation helpers for error, square, SSE and signed-sum paths
// No ports (package).
// ----------------------------------------------------------------------------
package approx_err_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_WIN_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Signed error: exact sum is WIDTH+1 unsigned, so the difference of two
    // WIDTH+1 unsigned values needs WIDTH+2 signed bits.
    function automatic int err_w(input int width);
        return width + 2;
    endfunction

    function automatic int sq_w(input int width);
        return 2 * err_w(width);
    endfunction

    // Window of 2**win_log2 squares never exceeds this width.
    function automatic int sse_w(input int width, input int win_log2);
        return 2 * width + 4 + win_log2;
    endfunction

    function automatic int sum_w(input int width, input int win_log2);
        return width + 2 + win_log2;
    endfunction

endpackage

// File: rtl/approx_err_calc.sv
// ----------------------------------------------------------------------------
// approx_err_calc
// Combinational stage-1 error computation for one sample:
//   err = approx - (a + b), computed without truncation.
// Optional macro: APPROX_ERR_MAX_EN adds the |err| output used for max tracking.
// Ports:
//   a, b     in   WIDTH     operands of the monitored adder
//   approx   in   WIDTH+1   approximate sum under test
//   err      out  WIDTH+2   signed error
//   abs_err  out  WIDTH+2   magnitude of err (only with APPROX_ERR_MAX_EN)
// ----------------------------------------------------------------------------
module approx_err_calc
    import approx_err_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    input  logic [WIDTH:0]                   approx,
    output logic signed [err_w(WIDTH)-1:0]   err
`ifdef APPROX_ERR_MAX_EN
    ,
    output logic [err_w(WIDTH)-1:0]          abs_err
`endif
);

    localparam int EW = err_w(WIDTH);

    logic [WIDTH:0]  exact;
    logic [EW-1:0]   diff;

    assign exact = {1'b0, a} + {1'b0, b};
    // Both terms zero-extended to the error width; the true difference always
    // fits, so the two's-complement wrap of the subtraction is exact.
    assign diff  = {1'b0, approx} - {1'b0, exact};
    assign err   = $signed(diff);

`ifdef APPROX_ERR_MAX_EN
    // The reachable error range is [-(2**(WIDTH+1)-2), 2**(WIDTH+1)-1], so the
    // negation never hits the unrepresentable minimum of EW bits.
    assign abs_err = diff[EW-1] ? ((~diff) + EW'(1)) : diff;
`endif

endmodule

// File: rtl/approx_err_accum.sv
// ----------------------------------------------------------------------------
// approx_err_accum
// Measures the error of an approximate adder over windows of 2**WIN_LOG2
// samples. Stage 1 registers the signed error, stage 2 registers its square,
// and the accumulators gather SSE, signed error sum, nonzero-error count and
// (optionally) max |err|. The finished window is held until taken.
// Optional macro: APPROX_ERR_MAX_EN builds max-abs tracking; otherwise
// res_max_abs is tied to zero.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clr               synchronous abort of the current window (highest priority)
//   in_valid/in_ready sample handshake
//   in_a, in_b        operands (WIDTH)
//   in_approx         approximate sum (WIDTH+1)
//   res_valid/res_ready result handshake
//   res_sse           sum of squared errors
//   res_sum_err       signed sum of errors
//   res_max_abs       largest |err| in the window
//   res_err_cnt       number of samples with nonzero error
// ----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACCUM | accepting samples until the window's last one is taken
// ST_DRAIN | no new samples; waiting for the pipeline to empty
// ST_HOLD  | result valid and frozen until the consumer takes it
// ----------------------------------------------------------------------------
module approx_err_accum
    import approx_err_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH-1:0]                         in_a,
    input  logic [WIDTH-1:0]                         in_b,
    input  logic [WIDTH:0]                           in_approx,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [sse_w(WIDTH, WIN_LOG2)-1:0]        res_sse,
    output logic signed [sum_w(WIDTH, WIN_LOG2)-1:0] res_sum_err,
    output logic [WIDTH+1:0]                         res_max_abs,
    output logic [WIN_LOG2:0]                        res_err_cnt
);

    localparam int EW   = err_w(WIDTH);
    localparam int SQW  = sq_w(WIDTH);
    localparam int SSEW = sse_w(WIDTH, WIN_LOG2);

    state_t state;
    state_t state_next;

    logic                   accept;
    logic                   take;
    logic [WIN_LOG2-1:0]    sample_cnt;
    logic                   last_sample;

    logic signed [EW-1:0]   calc_err;
    logic                   s1_valid;
    logic signed [EW-1:0]   s1_err;
    logic signed [SQW-1:0]  sq_full;
    logic                   s2_valid;
    logic signed [EW-1:0]   s2_err;
    logic [SQW-1:0]         s2_sq;

`ifdef APPROX_ERR_MAX_EN
    logic [EW-1:0]          calc_abs;
    logic [EW-1:0]          s1_abs;
    logic [EW-1:0]          s2_abs;
`endif

    // clr wins over both handshakes in the same cycle.
    assign accept      = in_valid && in_ready && !clr;
    assign take        = res_valid && res_ready && !clr;
    assign last_sample = &sample_cnt;

    approx_err_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .a       (in_a),
        .b       (in_b),
        .approx  (in_approx),
        .err     (calc_err)
`ifdef APPROX_ERR_MAX_EN
        ,
        .abs_err (calc_abs)
`endif
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (accept && last_sample) state_next = ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !s2_valid) state_next = ST_HOLD;
            ST_HOLD:  if (take) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
        if (clr) state_next = ST_ACCUM;
    end

    // Handshake outputs are registered copies of the next state; in_ready
    // stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            in_ready   <= 1'b0;
            res_valid  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ST_ACCUM);
            res_valid <= (state_next == ST_HOLD);
            if (clr || take) begin
                sample_cnt <= '0;
            end else if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    assign sq_full = s1_err * s1_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_err      <= '0;
            s2_valid    <= 1'b0;
            s2_err      <= '0;
            s2_sq       <= '0;
            res_sse     <= '0;
            res_sum_err <= '0;
            res_err_cnt <= '0;
        end else if (clr) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            res_sse     <= '0;
            res_sum_err <= '0;
            res_err_cnt <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_err <= calc_err;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_err <= s1_err;
                s2_sq  <= sq_full;
            end
            // take only happens in ST_HOLD, where the pipeline is empty.
            if (take) begin
                res_sse     <= '0;
                res_sum_err <= '0;
                res_err_cnt <= '0;
            end else if (s2_valid) begin
                res_sse     <= res_sse + {{(SSEW-SQW){1'b0}}, s2_sq};
                res_sum_err <= res_sum_err + $signed({{WIN_LOG2{s2_err[EW-1]}}, s2_err});
                res_err_cnt <= res_err_cnt + {{WIN_LOG2{1'b0}}, (s2_err != '0)};
            end
        end
    end

`ifdef APPROX_ERR_MAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_abs      <= '0;
            s2_abs      <= '0;
            res_max_abs <= '0;
        end else if (clr) begin
            res_max_abs <= '0;
        end else begin
            if (accept)   s1_abs <= calc_abs;
            if (s1_valid) s2_abs <= s1_abs;
            if (take) begin
                res_max_abs <= '0;
            end else if (s2_valid && (s2_abs > res_max_abs)) begin
                res_max_abs <= s2_abs;
            end
        end
    end
`else
    assign res_max_abs = '0;
`endif

endmodule

// File: tb/tb_approx_err_accum.sv
// ----------------------------------------------------------------------------
// tb_approx_err_accum
// Directed bench for approx_err_accum with WIDTH=8, WIN_LOG2=2 (4-sample
// windows). Expected values are hand-computed; max-abs expectations follow
// the APPROX_ERR_MAX_EN build option.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_approx_err_accum;

    localparam int WIDTH    = 8;
    localparam int WIN_LOG2 = 2;

`ifdef APPROX_ERR_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_a;
    logic [7:0]         in_b;
    logic [8:0]         in_approx;
    logic               res_valid;
    logic               res_ready;
    logic [21:0]        res_sse;
    logic signed [11:0] res_sum_err;
    logic [9:0]         res_max_abs;
    logic [2:0]         res_err_cnt;

    int checks = 0;
    int errors = 0;
    int lat;

    approx_err_accum #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_approx   (in_approx),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sse     (res_sse),
        .res_sum_err (res_sum_err),
        .res_max_abs (res_max_abs),
        .res_err_cnt (res_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one sample across the next rising edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
        chk("ready_at_send", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Counts rising edges after the last acceptance until res_valid is seen.
    task automatic wait_res(output int k);
        k = 0;
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_res(input string tag, input logic [21:0] sse, input logic [11:0] sum,
                             input logic [2:0] cnt, input logic [9:0] mx);
        chk({tag, "_sse"}, {42'd0, res_sse}, {42'd0, sse});
        chk({tag, "_sum"}, {52'd0, res_sum_err}, {52'd0, sum});
        chk({tag, "_cnt"}, {61'd0, res_err_cnt}, {61'd0, cnt});
        chk({tag, "_max"}, {54'd0, res_max_abs}, MAX_EN ? {54'd0, mx} : 64'd0);
    endtask

    task automatic do_take();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("take_valid_low", {63'd0, res_valid}, 64'd0);
        chk("take_ready_high", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_approx = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check_res("rst", 22'd0, 12'd0, 3'd0, 10'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Window 1: exact sums, all errors zero
        repeat (4) send(8'd3, 8'd5, 9'd8);
        chk("w1_drain_ready", {63'd0, in_ready}, 64'd0);
        wait_res(lat);
        chk("w1_latency", 64'(lat), 64'd3);
        check_res("w1", 22'd0, 12'd0, 3'd0, 10'd0);
        do_take();

        // Window 2: errors +1,-2,0,+3
        send(8'd10, 8'd20, 9'd31);
        send(8'd10, 8'd20, 9'd28);
        send(8'd10, 8'd20, 9'd30);
        send(8'd10, 8'd20, 9'd33);
        wait_res(lat);
        chk("w2_latency", 64'(lat), 64'd3);
        check_res("w2", 22'd14, 12'd2, 3'd3, 10'd3);

        // Hold for 10 cycles with a sample pending: nothing may move
        in_valid  = 1'b1;
        in_a      = 8'd200;
        in_b      = 8'd1;
        in_approx = 9'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_sse", {42'd0, res_sse}, 64'd14);
            chk("hold_sum", {52'd0, res_sum_err}, 64'd2);
        end
        in_valid = 1'b0;
        check_res("w2_hold_end", 22'd14, 12'd2, 3'd3, 10'd3);
        do_take();

        // Window 3 must start from zero: four errors of -1
        repeat (4) send(8'd1, 8'd1, 9'd1);
        wait_res(lat);
        chk("w3_latency", 64'(lat), 64'd3);
        check_res("w3", 22'd4, 12'hFFC, 3'd4, 10'd1);
        do_take();

        // clr with the 3rd sample aborts the window
        send(8'd10, 8'd20, 9'd35);
        send(8'd10, 8'd20, 9'd35);
        clr = 1'b1;
        send(8'd10, 8'd20, 9'd35);
        clr = 1'b0;
        chk("clr_ready", {63'd0, in_ready}, 64'd1);
        chk("clr_valid", {63'd0, res_valid}, 64'd0);
        chk("clr_sse", {42'd0, res_sse}, 64'd0);
        chk("clr_cnt", {61'd0, res_err_cnt}, 64'd0);
        // Next four samples alone form the result: +2,0,-1,+1
        send(8'd10, 8'd20, 9'd32);
        send(8'd10, 8'd20, 9'd30);
        send(8'd10, 8'd20, 9'd29);
        send(8'd10, 8'd20, 9'd31);
        wait_res(lat);
        chk("w4_latency", 64'(lat), 64'd3);
        check_res("w4", 22'd6, 12'd2, 3'd3, 10'd2);
        do_take();

        // Most negative error: 0 - (255+255) = -510
        send(8'd255, 8'd255, 9'd0);
        repeat (3) send(8'd0, 8'd0, 9'd0);
        wait_res(lat);
        chk("w5_latency", 64'(lat), 64'd3);
        check_res("w5", 22'h3F804, 12'hE02, 3'd1, 10'd510);

        // clr during HOLD beats a same-cycle take and drops the result
        clr       = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr       = 1'b0;
        res_ready = 1'b0;
        chk("hold_clr_valid", {63'd0, res_valid}, 64'd0);
        chk("hold_clr_ready", {63'd0, in_ready}, 64'd1);
        check_res("hold_clr", 22'd0, 12'd0, 3'd0, 10'd0);

        // Reset while draining: window lost, no result
        repeat (4) send(8'd10, 8'd20, 9'd33);
        chk("w6_in_drain", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        check_res("mid_rst", 22'd0, 12'd0, 3'd0, 10'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_hold_valid", {63'd0, res_valid}, 64'd0);
            chk("rst_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst2_valid", {63'd0, res_valid}, 64'd0);
        end
        chk("post_rst2_ready", {63'd0, in_ready}, 64'd1);
        check_res("post_rst2", 22'd0, 12'd0, 3'd0, 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_err_accum.md
APPROX_ERR_ACCUM -- requirements
Module: approx_err_accum

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the monitored adder; approximate sum width is WIDTH+1.
REQ-002 Parameter WIN_LOG2, default 8: window length is 2**WIN_LOG2 samples.
REQ-003 Port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port clr  input  1: synchronous abort of the current window.
REQ-006 Port in_valid  input  1: sample present.
REQ-007 Port in_ready  output  1: block accepts a sample this cycle.
REQ-008 Port in_a, in_b  input  WIDTH each: operands applied to the approximate adder.
REQ-009 Port in_approx  input  WIDTH+1: approximate adder sum for in_a and in_b.
REQ-010 Port res_valid  output  1: window result held.
REQ-011 Port res_ready  input  1: consumer takes the result.
REQ-012 Port res_sse  output  2*WIDTH+4+WIN_LOG2: sum of squared errors over the window.
REQ-013 Port res_sum_err  output  WIDTH+2+WIN_LOG2, signed: sum of signed errors.
REQ-014 Port res_max_abs  output  WIDTH+2: largest absolute error in the window.
REQ-015 Port res_err_cnt  output  WIN_LOG2+1: count of samples with nonzero error.

Function
REQ-016 Handshakes: a sample is accepted when in_valid and in_ready are both high; a result is taken when res_valid and res_ready are both high.
REQ-017 Error: err = in_approx - (in_a + in_b); exact sum is WIDTH+1 bits, unsigned; err is WIDTH+2 bits, signed, with no truncation.
REQ-018 Pipeline stage 1 registers err; stage 2 registers err*err and accumulates all four metrics; there is no bubble for back-to-back samples.
REQ-019 FSM states: ACCUM, DRAIN, HOLD.
REQ-020 ACCUM: in_ready=1; on acceptance of sample number 2**WIN_LOG2, go to DRAIN.
REQ-021 DRAIN: in_ready=0; go to HOLD once the last sample has left stage 2.
REQ-022 HOLD: res_valid=1; outputs stable until taken. On take: zero all accumulators and the sample counter, go to ACCUM; in_ready rises on the next edge.
REQ-023 Latency: last sample accepted on edge E; res_valid rises on edge E+3.
REQ-024 Accumulators cannot overflow at the declared widths, so no saturation is implemented.
REQ-025 clr in any state: discard the pipeline contents, accumulators, counter and any held result; go to ACCUM next edge.
REQ-026 clr takes priority over a same-cycle sample acceptance or result take; neither is counted.
REQ-027 res_max_abs uses |err|; the most negative err maps to its full magnitude without wrap.
REQ-028 Outputs are registered; result fields are don't-care while res_valid=0, but are driven from the accumulators.

Reset
REQ-029 rst_n low: state ACCUM, in_ready=0 while asserted, res_valid=0, all accumulators, counter and pipeline valids 0.
REQ-030 in_ready is 1 from the first edge after rst_n deasserts; reset mid-window loses that window with no result.

Configuration
REQ-031 Macro APPROX_ERR_MAX_EN defined: max-abs tracking is built and res_max_abs is valid.
REQ-032 Macro APPROX_ERR_MAX_EN undefined: no max-abs logic; res_max_abs is tied 0; all other behaviour is identical.

Structure
REQ-033 Package approx_err_pkg holds the FSM state enum, the width-derivation constants (error, SSE and sum widths) and the default WIDTH/WIN_LOG2.
REQ-034 Sub-module approx_err_calc holds the stage-1 error computation (exact add, subtract, abs); the FSM and accumulators stay in the top.

Verification
REQ-035 WIN_LOG2=2, four samples a=3,b=5,approx=8 -> res_sse=0, res_sum_err=0, res_err_cnt=0, res_max_abs=0.
REQ-036 WIN_LOG2=2, approx errors +1,-2,0,+3 -> res_sse=14, res_sum_err=2, res_err_cnt=3, res_max_abs=3 on edge E+3.
REQ-037 Hold res_ready=0 for 10 cycles -> in_ready=0 and outputs stable throughout; take -> next window starts from zero.
REQ-038 Assert clr together with the 3rd sample of a window -> no result; the next 4 samples alone form the result.
REQ-039 Assert rst_n low mid-DRAIN -> res_valid never rises; outputs match REQ-029.
REQ-040 Build without APPROX_ERR_MAX_EN and rerun REQ-036 -> identical results except res_max_abs=0.
